// File: rtl/ir_beacon_pkg.sv
// Beacon code values, default gate/band settings and the window classifier shared
// by the classifier instances, the display stage and steering logic.
package ir_beacon_pkg;

    localparam logic [1:0] SIG_NONE = 2'b00;
    localparam logic [1:0] SIG_LO   = 2'b01;
    localparam logic [1:0] SIG_HI   = 2'b10;
    localparam logic [1:0] SIG_RSVD = 2'b11;

    localparam int unsigned DEF_GATE_CYCLES = 10_000_000;
    localparam int unsigned DEF_LO_MIN      = 90;
    localparam int unsigned DEF_LO_MAX      = 110;
    localparam int unsigned DEF_HI_MIN      = 900;
    localparam int unsigned DEF_HI_MAX      = 1100;
    localparam int unsigned DEF_CONFIRM     = 2;

    // Low band is tested first so it wins if the bands ever overlap.
    function automatic logic [1:0] classify(
        input logic [15:0] n,
        input logic [15:0] lo_min,
        input logic [15:0] lo_max,
        input logic [15:0] hi_min,
        input logic [15:0] hi_max
    );
        if (n >= lo_min && n <= lo_max) begin
            return SIG_LO;
        end
        if (n >= hi_min && n <= hi_max) begin
            return SIG_HI;
        end
        return SIG_NONE;
    endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for the asynchronous IR input.
// Latency: rise pulses in the third cycle after ir_in goes high; no backpressure.
module ir_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic ir_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/ir_beacon_classifier.sv
// Counts IR rising edges per gate window, classifies the count into a beacon code and debounces it.
// Latency: result one cycle after the window's terminal cycle; no backpressure, win_valid is a pulse.
module ir_beacon_classifier
    import ir_beacon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned LO_MIN      = DEF_LO_MIN,
    parameter int unsigned LO_MAX      = DEF_LO_MAX,
    parameter int unsigned HI_MIN      = DEF_HI_MIN,
    parameter int unsigned HI_MAX      = DEF_HI_MAX,
    parameter int unsigned CONFIRM     = DEF_CONFIRM
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        ir_in,
    output logic [1:0]  sig,
    output logic        win_valid,
    output logic [15:0] last_count
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [3:0]    CONFIRM_W = 4'(CONFIRM);

    if (LO_MAX >= 65535 || HI_MAX >= 65535 || CONFIRM < 1 || CONFIRM > 15 || GATE_CYCLES < 2) begin : g_param_err
        $error("ir_beacon_classifier: illegal parameter set");
    end

    logic [GW-1:0] gate;
    logic [15:0]   edge_cnt;
    logic [1:0]    candidate;
    logic [3:0]    agree_cnt;
    logic [3:0]    agree_next;
    logic          rise;
    logic          terminal;
    logic [16:0]   sum;
    logic [15:0]   n_close;
    logic [1:0]    code;

    ir_edge_sync u_edge_sync (
        .clock (clock),
        .reset (reset),
        .ir_in (ir_in),
        .rise  (rise)
    );

    assign terminal = (gate == GATE_LAST);

    // An edge seen on the terminal cycle still belongs to the closing window.
    assign sum     = {1'b0, edge_cnt} + {16'd0, rise};
    assign n_close = sum[16] ? 16'hFFFF : sum[15:0];
    assign code    = classify(n_close, 16'(LO_MIN), 16'(LO_MAX), 16'(HI_MIN), 16'(HI_MAX));

    always_comb begin
        agree_next = 4'd1;
        if (code == candidate) begin
            agree_next = (agree_cnt >= CONFIRM_W) ? CONFIRM_W : agree_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gate       <= '0;
            edge_cnt   <= '0;
            candidate  <= SIG_NONE;
            agree_cnt  <= '0;
            sig        <= SIG_NONE;
            win_valid  <= 1'b0;
            last_count <= '0;
        end else if (!enable) begin
            gate      <= '0;
            edge_cnt  <= '0;
            candidate <= SIG_NONE;
            agree_cnt <= '0;
            sig       <= SIG_NONE;
            win_valid <= 1'b0;
        end else begin
            win_valid <= terminal;
            if (terminal) begin
                gate       <= '0;
                edge_cnt   <= '0;
                last_count <= n_close;
                candidate  <= code;
                agree_cnt  <= agree_next;
                if (agree_next == CONFIRM_W) begin
                    sig <= code;
                end
            end else begin
                gate     <= gate + GW'(1);
                edge_cnt <= n_close;
            end
        end
    end

endmodule

// File: tb/tb_ir_beacon_classifier.sv
// Directed bench for ir_beacon_classifier with a 1000-cycle window, LO 9..11, HI 90..110, CONFIRM 2.
module tb_ir_beacon_classifier;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        ir_in = 1'b0;
    logic [1:0]  sig;
    logic        win_valid;
    logic [15:0] last_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int en_cyc;

    int          wv_cyc[$];
    logic [1:0]  wv_sig[$];
    logic [1:0]  wv_cand[$];
    logic [15:0] wv_cnt[$];

    always #5 clock = ~clock;

    ir_beacon_classifier #(
        .GATE_CYCLES (1000),
        .LO_MIN      (9),
        .LO_MAX      (11),
        .HI_MIN      (90),
        .HI_MAX      (110),
        .CONFIRM     (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .ir_in      (ir_in),
        .sig        (sig),
        .win_valid  (win_valid),
        .last_count (last_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_wv();
        wv_cyc.delete();
        wv_sig.delete();
        wv_cand.delete();
        wv_cnt.delete();
    endtask

    // One call step = one clock; period 0 holds ir_in at lvl, else a 50% square wave.
    task automatic drive(input int period, input int n, input logic lvl);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            cyc++;
            #1 ir_in = (period == 0) ? lvl : (((cyc - 1) % period) < (period / 2));
            @(negedge clock);
            if (win_valid) begin
                wv_cyc.push_back(cyc);
                wv_sig.push_back(sig);
                wv_cand.push_back(dut.candidate);
                wv_cnt.push_back(last_count);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        ir_in  = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        clear_wv();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_sig", 32'(sig), 0);
        check("rst_win_valid", 32'(win_valid), 0);
        check("rst_last_count", 32'(last_count), 0);

        // 1: period 100 -> 10 edges per window, sig 01 after second window
        do_reset();
        drive(100, 2000, 1'b0);
        check("t1_nwv", 32'(wv_cyc.size()), 2);
        check("t1_wv0_cyc", 32'(wv_cyc[0]), 1000);
        check("t1_wv1_cyc", 32'(wv_cyc[1]), 2000);
        check("t1_cnt0", 32'(wv_cnt[0]), 10);
        check("t1_cnt1", 32'(wv_cnt[1]), 10);
        check("t1_sig0", 32'(wv_sig[0]), 0);
        check("t1_sig1", 32'(wv_sig[1]), 1);

        // 2: period 10 for three windows, then ir_in low
        do_reset();
        drive(10, 3000, 1'b0);
        drive(0, 2000, 1'b0);
        check("t2_nwv", 32'(wv_cyc.size()), 5);
        begin
            int e_sig[5] = '{0, 2, 2, 2, 0};
            int e_cnt[5] = '{100, 100, 100, 0, 0};
            for (int k = 0; k < 5; k++) begin
                check($sformatf("t2_sig%0d", k), 32'(wv_sig[k]), 32'(e_sig[k]));
                check($sformatf("t2_cnt%0d", k), 32'(wv_cnt[k]), 32'(e_cnt[k]));
            end
        end

        // 3: alternating low/high beacon windows never confirm
        do_reset();
        for (int w = 0; w < 4; w++) begin
            drive((w % 2 == 1) ? 10 : 100, 1000, 1'b0);
        end
        check("t3_nwv", 32'(wv_cyc.size()), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_sig%0d", k), 32'(wv_sig[k]), 0);
            check($sformatf("t3_cand%0d", k), 32'(wv_cand[k]), (k % 2 == 1) ? 2 : 1);
            check($sformatf("t3_cnt%0d", k), 32'(wv_cnt[k]), (k % 2 == 1) ? 100 : 10);
        end

        // 4: eleventh edge detected exactly on the terminal cycle
        do_reset();
        drive(100, 996, 1'b0);
        drive(0, 50, 1'b1);
        drive(0, 954, 1'b0);
        check("t4_nwv", 32'(wv_cyc.size()), 2);
        check("t4_cnt0", 32'(wv_cnt[0]), 11);
        check("t4_cand0", 32'(wv_cand[0]), 1);
        check("t4_sig0", 32'(wv_sig[0]), 0);
        check("t4_cnt1", 32'(wv_cnt[1]), 0);
        check("t4_cand1", 32'(wv_cand[1]), 0);

        // 5: reset mid-window while sig = 01
        do_reset();
        drive(100, 2500, 1'b0);
        check("t5_pre_sig", 32'(sig), 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        cyc = 0;
        clear_wv();
        @(negedge clock);
        check("t5_sig", 32'(sig), 0);
        check("t5_last_count", 32'(last_count), 0);
        check("t5_win_valid", 32'(win_valid), 0);
        drive(100, 1000, 1'b0);
        check("t5_nwv", 32'(wv_cyc.size()), 1);
        check("t5_wv_cyc", 32'(wv_cyc[0] >= 999 && wv_cyc[0] <= 1001), 1);
        check("t5_cnt", 32'(wv_cnt[0]), 10);
        check("t5_sig0", 32'(wv_sig[0]), 0);

        // 6: enable low for five cycles while sig = 10
        do_reset();
        drive(10, 2300, 1'b0);
        check("t6_pre_sig", 32'(sig), 2);
        check("t6_pre_cnt", 32'(last_count), 100);
        enable = 1'b0;
        clear_wv();
        drive(10, 1, 1'b0);
        check("t6_off_sig", 32'(sig), 0);
        check("t6_off_cnt", 32'(last_count), 100);
        check("t6_off_wv", 32'(win_valid), 0);
        drive(10, 4, 1'b0);
        enable = 1'b1;
        en_cyc = cyc;
        drive(10, 1000, 1'b0);
        check("t6_nwv", 32'(wv_cyc.size()), 1);
        check("t6_wv_cyc", 32'(wv_cyc[0]), 32'(en_cyc + 1000));
        check("t6_cnt", 32'(wv_cnt[0]), 100);
        check("t6_sig", 32'(wv_sig[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
